// File: rtl/brownout_pkg.sv
// Shared types and helpers for the brownout digital controller.
package brownout_pkg;

  localparam int TRIP_W = 3;
  localparam int DEC_W  = 8;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MONITOR = 3'd2,
    ST_TRIP    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  function automatic logic [DEC_W-1:0] trip_decode(input logic [TRIP_W-1:0] v);
    logic [DEC_W-1:0] onehot;
    onehot    = '0;
    onehot[v] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/brownout_dig_sync.sv
// Multi-flop synchroniser for one asynchronous comparator output.
module brownout_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic osc_ck,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/brownout_dig.sv
// Brownout controller: trip decodes, comparator settling blanking and
// minimum-width stretching of the brownout output.
module brownout_dig
  import brownout_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int HOLD_CYCLES   = 1024,
  parameter int HOLD_SHORT    = 16,
  parameter int CNT_W         = 11
) (
  input  logic              osc_ck,
  input  logic              rstn,
  input  logic              ena,
  input  logic [TRIP_W-1:0] otrip,
  input  logic [TRIP_W-1:0] vtrip,
  input  logic              short_hold,
  input  logic              brout_filt,
  input  logic              vunder,
  input  logic              vunder_clr,
  output logic [DEC_W-1:0]  otrip_decoded,
  output logic [DEC_W-1:0]  vtrip_decoded,
  output logic              osc_ena,
  output logic              out_unbuf,
  output logic              vunder_sync,
  output logic              vunder_sticky,
  output logic [2:0]        state_o
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD     = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LONG_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SHORT_LOAD = CNT_W'(HOLD_SHORT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

  logic              brout_s;
  logic              vunder_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRIP_W-1:0] otrip_q, vtrip_q;
  logic [DEC_W-1:0]  otrip_dec_q, vtrip_dec_q;
  logic              out_q;
  logic              sticky_q, sticky_d;
  logic              trip_chg;
  logic              observing;

  brownout_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_brout (
    .osc_ck (osc_ck),
    .rstn   (rstn),
    .d_i    (brout_filt),
    .q_o    (brout_s)
  );

  brownout_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vunder (
    .osc_ck (osc_ck),
    .rstn   (rstn),
    .d_i    (vunder),
    .q_o    (vunder_s)
  );

  // A new trip code retunes the comparator, so it must settle again.
  assign trip_chg = (otrip != otrip_q) || (vtrip != vtrip_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ena) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (state_q == ST_OFF || trip_chg) begin
      state_d = ST_SETTLE;
      cnt_d   = SETTLE_LOAD;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = brout_s ? ST_TRIP : ST_MONITOR;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_MONITOR: begin
          if (brout_s) state_d = ST_TRIP;
        end
        ST_TRIP: begin
          if (!brout_s) begin
            state_d = ST_HOLD;
            cnt_d   = short_hold ? HOLD_SHORT_LOAD : HOLD_LONG_LOAD;
          end
        end
        ST_HOLD: begin
          if (brout_s) begin
            state_d = ST_TRIP;
          end else if (cnt_q == '0) begin
            state_d = ST_MONITOR;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign observing   = (state_q == ST_MONITOR) || (state_q == ST_TRIP) || (state_q == ST_HOLD);
  assign vunder_sync = vunder_s && observing;

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == ST_OFF) begin
      sticky_d = 1'b0;
    end else if (vunder_sync) begin
      sticky_d = 1'b1;
    end else if (vunder_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      otrip_q     <= '0;
      vtrip_q     <= '0;
      otrip_dec_q <= '0;
      vtrip_dec_q <= '0;
      out_q       <= 1'b1;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      otrip_q     <= otrip;
      vtrip_q     <= vtrip;
      otrip_dec_q <= ena ? trip_decode(otrip) : '0;
      vtrip_dec_q <= ena ? trip_decode(vtrip) : '0;
      out_q       <= (state_d != ST_MONITOR);
      sticky_q    <= sticky_d;
    end
  end

  assign osc_ena       = ena;
  assign out_unbuf     = out_q;
  assign vunder_sticky = sticky_q;
  assign otrip_decoded = otrip_dec_q;
  assign vtrip_decoded = vtrip_dec_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_brownout_dig.sv
// Randomised and directed bench for brownout_dig against a behavioural model.
module tb_brownout_dig;

  localparam int SYNC_STAGES   = 2;
  localparam int SETTLE_CYCLES = 64;
  localparam int HOLD_CYCLES   = 1024;
  localparam int HOLD_SHORT    = 16;

  logic       osc_ck = 1'b0;
  logic       rstn;
  logic       ena;
  logic [2:0] otrip, vtrip;
  logic       short_hold, brout_filt, vunder, vunder_clr;
  logic [7:0] otrip_decoded, vtrip_decoded;
  logic       osc_ena, out_unbuf, vunder_sync, vunder_sticky;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  brownout_dig #(
    .SYNC_STAGES(SYNC_STAGES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .HOLD_SHORT(HOLD_SHORT), .CNT_W(11)
  ) dut (
    .osc_ck(osc_ck), .rstn(rstn), .ena(ena), .otrip(otrip), .vtrip(vtrip),
    .short_hold(short_hold), .brout_filt(brout_filt), .vunder(vunder),
    .vunder_clr(vunder_clr), .otrip_decoded(otrip_decoded),
    .vtrip_decoded(vtrip_decoded), .osc_ena(osc_ena), .out_unbuf(out_unbuf),
    .vunder_sync(vunder_sync), .vunder_sticky(vunder_sticky), .state_o(state_o)
  );

  always #5 osc_ck = ~osc_ck;

  // Reference model: "on" = powered, "settling" = blanking window age,
  // "alarm" = brownout latched, "releasing" = counting quiet cycles.
  logic [SYNC_STAGES-1:0] m_bs, m_vs;
  bit   m_on, m_settling, m_alarm, m_releasing, m_sticky;
  int   m_age, m_quiet, m_hl;
  logic [2:0] m_oprev, m_vprev;
  logic [7:0] m_odec, m_vdec;

  function automatic logic [2:0] m_state();
    if (!m_on) return 3'd0;
    if (m_settling) return 3'd1;
    if (m_alarm && !m_releasing) return 3'd3;
    if (m_alarm) return 3'd4;
    return 3'd2;
  endfunction

  function automatic logic [22:0] exp_vec();
    logic [2:0] st;
    logic vs;
    st = m_state();
    vs = m_vs[SYNC_STAGES-1] && (st >= 3'd2);
    return {st, (st != 3'd2), vs, m_sticky, ena, m_odec, m_vdec};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {state_o, out_unbuf, vunder_sync, vunder_sticky, osc_ena, otrip_decoded, vtrip_decoded};
  endfunction

  always @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      m_bs = '0; m_vs = '0;
      m_on = 0; m_settling = 0; m_alarm = 0; m_releasing = 0; m_sticky = 0;
      m_age = 0; m_quiet = 0; m_hl = HOLD_CYCLES;
      m_oprev = '0; m_vprev = '0; m_odec = '0; m_vdec = '0;
    end else begin
      logic bs, vsync_pre, chg;
      logic [2:0] st_pre;
      bs        = m_bs[SYNC_STAGES-1];
      st_pre    = m_state();
      vsync_pre = m_vs[SYNC_STAGES-1] && (st_pre >= 3'd2);
      if (st_pre == 3'd0) m_sticky = 0;
      else if (vsync_pre) m_sticky = 1;
      else if (vunder_clr) m_sticky = 0;
      chg = (otrip != m_oprev) || (vtrip != m_vprev);
      if (!ena) begin
        m_on = 0; m_settling = 0; m_alarm = 0; m_releasing = 0;
      end else if (!m_on || chg) begin
        m_on = 1; m_settling = 1; m_age = 0; m_alarm = 0; m_releasing = 0;
      end else if (m_settling) begin
        if (m_age == SETTLE_CYCLES - 1) begin
          m_settling = 0; m_alarm = bs; m_releasing = 0;
        end else m_age++;
      end else if (!m_alarm) begin
        if (bs) m_alarm = 1;
      end else if (!m_releasing) begin
        if (!bs) begin
          m_releasing = 1; m_quiet = 0; m_hl = short_hold ? HOLD_SHORT : HOLD_CYCLES;
        end
      end else if (bs) begin
        m_releasing = 0;
      end else if (m_quiet == m_hl - 1) begin
        m_alarm = 0; m_releasing = 0;
      end else m_quiet++;
      m_odec  = ena ? (8'd1 << otrip) : 8'd0;
      m_vdec  = ena ? (8'd1 << vtrip) : 8'd0;
      m_oprev = otrip;
      m_vprev = vtrip;
      m_bs    = {m_bs[SYNC_STAGES-2:0], brout_filt};
      m_vs    = {m_vs[SYNC_STAGES-2:0], vunder};
    end
  end

  task automatic test_reset();
    rstn = 0; ena = 1; otrip = 3'd5; vtrip = 3'd1;
    repeat (3) @(negedge osc_ck);
    checks++;
    if ({state_o, out_unbuf, vunder_sync, vunder_sticky, otrip_decoded, vtrip_decoded} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d out=%b vs=%b stk=%b od=%h vd=%h, expected st=0 out=1 vs=0 stk=0 od=00 vd=00",
               state_o, out_unbuf, vunder_sync, vunder_sticky, otrip_decoded, vtrip_decoded);
    end
    checks++;
    if (osc_ena !== 1'b1) begin errors++; $display("FAIL reset_osc_ena: got %b expected 1", osc_ena); end
    ena = 0; otrip = 0; vtrip = 0;
    @(negedge osc_ck);
    rstn = 1;
    $display("reset: checked");
  endtask

  task automatic test_power_up();
    int hi = 0;
    bit seen_low = 0;
    otrip = 3'd3; vtrip = 3'd2; brout_filt = 0; ena = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL power_up cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (!seen_low) begin
        if (out_unbuf === 1'b1) hi++; else seen_low = 1;
      end
    end
    checks++;
    if (hi != SETTLE_CYCLES) begin errors++; $display("FAIL power_up_settle_len: got %0d expected %0d", hi, SETTLE_CYCLES); end
    checks++;
    if ({state_o, out_unbuf, otrip_decoded, vtrip_decoded, osc_ena} !== {3'd2, 1'b0, 8'h08, 8'h04, 1'b1}) begin
      errors++;
      $display("FAIL power_up_final: got st=%0d out=%b od=%h vd=%h osc=%b expected st=2 out=0 od=08 vd=04 osc=1",
               state_o, out_unbuf, otrip_decoded, vtrip_decoded, osc_ena);
    end
    $display("power_up: settle high cycles=%0d", hi);
  endtask

  task automatic test_pulse(input bit short_mode);
    int hl = short_mode ? HOLD_SHORT : HOLD_CYCLES;
    int lat = 0;
    int rel = 0;
    short_hold = short_mode;
    brout_filt = 1;
    for (int i = 0; i < hl + 22; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL pulse cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (lat == 0 && out_unbuf === 1'b1) lat = i + 1;
      if (i >= 10 && out_unbuf === 1'b1) rel++;
      if (i == 9) brout_filt = 0;
    end
    checks++;
    if (lat != SYNC_STAGES + 1) begin errors++; $display("FAIL pulse_latency: got %0d expected %0d", lat, SYNC_STAGES + 1); end
    checks++;
    if (rel != SYNC_STAGES + hl) begin errors++; $display("FAIL pulse_hold_len: got %0d expected %0d", rel, SYNC_STAGES + hl); end
    checks++;
    if (state_o !== 3'd2 || out_unbuf !== 1'b0) begin
      errors++; $display("FAIL pulse_end: got st=%0d out=%b expected st=2 out=0", state_o, out_unbuf);
    end
    $display("pulse short=%0d: latency=%0d hold=%0d", short_mode, lat, rel);
  endtask

  task automatic test_retrigger();
    int rel = 0;
    int early_low = 0;
    short_hold = 0;
    brout_filt = 1;
    for (int i = 0; i < 1560; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL retrigger cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (i >= 3 && i < 520 && out_unbuf !== 1'b1) early_low++;
      if (i >= 520 && out_unbuf === 1'b1) rel++;
      if (i == 511) begin
        checks++;
        if (state_o !== 3'd4) begin errors++; $display("FAIL retrigger_in_hold: got st=%0d expected 4", state_o); end
      end
      if (i == 516) begin
        checks++;
        if (state_o !== 3'd3) begin errors++; $display("FAIL retrigger_trip: got st=%0d expected 3", state_o); end
      end
      if (i == 9) brout_filt = 0;
      if (i == 512) brout_filt = 1;
      if (i == 519) brout_filt = 0;
    end
    checks++;
    if (early_low != 0) begin errors++; $display("FAIL retrigger_gap: got %0d low cycles expected 0", early_low); end
    checks++;
    if (rel != SYNC_STAGES + HOLD_CYCLES) begin errors++; $display("FAIL retrigger_hold_len: got %0d expected %0d", rel, SYNC_STAGES + HOLD_CYCLES); end
    $display("retrigger: hold after re-release=%0d", rel);
  endtask

  task automatic test_trip_change();
    int hi = 0;
    bit seen_low = 0;
    checks++;
    if (vtrip_decoded !== 8'h04) begin errors++; $display("FAIL trip_change_pre: got %h expected 04", vtrip_decoded); end
    vtrip = 3'd5;
    for (int i = 0; i < 80; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL trip_change cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (i == 0) begin
        checks++;
        if (vtrip_decoded !== 8'h20 || state_o !== 3'd1) begin
          errors++; $display("FAIL trip_change_enter: got vd=%h st=%0d expected vd=20 st=1", vtrip_decoded, state_o);
        end
      end
      if (!seen_low) begin
        if (out_unbuf === 1'b1) hi++; else seen_low = 1;
      end
      brout_filt = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    checks++;
    if (hi != SETTLE_CYCLES) begin errors++; $display("FAIL trip_change_blank: got %0d expected %0d", hi, SETTLE_CYCLES); end
    $display("trip_change: blanking cycles=%0d", hi);
  endtask

  task automatic test_vunder();
    vunder = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL vunder_set cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (i == 2) vunder = 0;
    end
    checks++;
    if (vunder_sticky !== 1'b1 || vunder_sync !== 1'b0) begin
      errors++; $display("FAIL vunder_sticky_hold: got stk=%b vs=%b expected stk=1 vs=0", vunder_sticky, vunder_sync);
    end
    vunder_clr = 1;
    @(negedge osc_ck);
    vunder_clr = 0;
    checks++;
    if (vunder_sticky !== 1'b0) begin errors++; $display("FAIL vunder_clear: got %b expected 0", vunder_sticky); end
    ena = 0;
    #1;
    checks++;
    if (osc_ena !== 1'b0) begin errors++; $display("FAIL osc_ena_off: got %b expected 0", osc_ena); end
    for (int i = 0; i < 10; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL disable cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if (i == 0) begin
        checks++;
        if ({state_o, otrip_decoded, vtrip_decoded, out_unbuf} !== {3'd0, 8'h00, 8'h00, 1'b1}) begin
          errors++; $display("FAIL disable_state: got st=%0d od=%h vd=%h out=%b expected st=0 od=00 vd=00 out=1",
                             state_o, otrip_decoded, vtrip_decoded, out_unbuf);
        end
      end
    end
    $display("vunder: sticky set, cleared, disabled");
  endtask

  task automatic test_random();
    ena = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge osc_ck);
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      if ($urandom_range(0, 39) == 0) brout_filt = ~brout_filt;
      if ($urandom_range(0, 49) == 0) vunder = ~vunder;
      vunder_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) otrip = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) vtrip = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 699) == 0) ena = ~ena;
      if ($urandom_range(0, 99) == 0) short_hold = ($urandom_range(0, 7) != 0);
    end
    $display("random: 4000 cycles compared");
  endtask

  initial begin
    rstn = 0; ena = 0; otrip = 0; vtrip = 0; short_hold = 0;
    brout_filt = 0; vunder = 0; vunder_clr = 0;
    test_reset();
    test_power_up();
    test_pulse(1'b0);
    test_pulse(1'b1);
    test_retrigger();
    test_trip_change();
    test_vunder();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/brownout_dig.md
Name: brownout_dig

Overview:
- Digital controller on the far side of the brownout analog macro. It drives that macro's trip-select decodes, enable, oscillator enable and unbuffered output.
- Consumes the macro's raw comparator outputs (brout_filt, vunder) and its oscillator clock (osc_ck).
- Synchronises the comparator outputs and blanks them during comparator settling.
- Stretches each brownout event into a minimum-width reset pulse on out_unbuf.

Parameters:
- SYNC_STAGES, 2, flop stages on each asynchronous comparator input (min 2).
- SETTLE_CYCLES, 64, osc_ck cycles of blanking after enable or a trip-code change.
- HOLD_CYCLES, 1024, out_unbuf stretch after brownout clears (normal mode).
- HOLD_SHORT, 16, stretch used when short_hold=1 (test mode).
- CNT_W, 11, counter width; must hold max(SETTLE_CYCLES, HOLD_CYCLES).

Ports:
- osc_ck  in  1  clock, from the analog RC oscillator.
- rstn  in  1  asynchronous active-low reset.
- ena  in  1  block enable (dvdd domain, static relative to osc_ck).
- otrip  in  3  brownout trip select, binary.
- vtrip  in  3  undervoltage trip select, binary.
- short_hold  in  1  selects HOLD_SHORT instead of HOLD_CYCLES.
- brout_filt  in  1  raw brownout comparator output; 1 = supply below trip; asynchronous.
- vunder  in  1  raw undervoltage flag; 1 = under; asynchronous.
- vunder_clr  in  1  clears the sticky undervoltage flag.
- otrip_decoded  out  8  one-hot otrip to the analog macro.
- vtrip_decoded  out  8  one-hot vtrip to the analog macro.
- osc_ena  out  1  oscillator enable.
- out_unbuf  out  1  stretched brownout output to the analog buffer.
- vunder_sync  out  1  synchronised, blanked vunder.
- vunder_sticky  out  1  latched undervoltage event.
- state_o  out  3  FSM state, for debug and observation.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=OFF; all counters 0; synchronisers 0; decodes 0.
  - out_unbuf=1 (fail-safe: brownout asserted); vunder_sync=0; vunder_sticky=0.
- osc_ena = ena, combinational. It is not gated by the FSM; the clock must run for the FSM to leave OFF.
- Decode outputs are registered:
  - ena=1: otrip_decoded = 1<<otrip, vtrip_decoded = 1<<vtrip, 1 cycle latency.
  - ena=0: both decodes are 0.
- Synchronisers: brout_s and vunder_s are SYNC_STAGES flops each. All FSM decisions use brout_s.
- FSM states: OFF, SETTLE, MONITOR, TRIP, HOLD.
  - OFF: out_unbuf=1. When ena=1, load cnt=SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: out_unbuf=1; cnt decrements each cycle. At cnt=0: brout_s=1 → TRIP, else → MONITOR.
  - MONITOR: out_unbuf=0. brout_s=1 → TRIP next cycle.
  - TRIP: out_unbuf=1. When brout_s=0, load cnt=hold_len-1 and go to HOLD.
  - HOLD: out_unbuf=1; cnt decrements each cycle.
    - brout_s=1 → TRIP; the counter reloads on the next exit from TRIP.
    - cnt=0 with brout_s=0 → MONITOR.
  - Any state: ena=0 → OFF next cycle. Counter is cleared; decodes go to 0.
  - Any state except OFF: a change in registered otrip or vtrip → SETTLE with cnt reloaded. This takes priority over brout_s.
- hold_len = short_hold ? HOLD_SHORT : HOLD_CYCLES, sampled at HOLD entry only.
- out_unbuf is registered. Brownout-to-output latency is SYNC_STAGES+1 cycles from the brout_filt edge.
- Counter never wraps: saturates at 0, loaded only at state entry.
- vunder handling:
  - vunder_sync = vunder_s when state is MONITOR, TRIP or HOLD; otherwise 0.
  - vunder_sticky sets on vunder_sync=1 and clears on vunder_clr=1.
  - Set wins on a simultaneous set and clear.
  - vunder_sticky is cleared in OFF.
- Glitches on brout_filt shorter than one osc_ck period may be missed. This is acceptable because the analog comparator filters them.

Decomposition:
- Package brownout_pkg holds:
  - state enum: OFF=0, SETTLE=1, MONITOR=2, TRIP=3, HOLD=4.
  - TRIP_W=3 and DEC_W=8 constants.
  - a decode function: 3-bit value to one-hot 8-bit.
- Sub-module brownout_sync: parameterised SYNC_STAGES flop chain with asynchronous reset to 0. Instantiated twice, once for brout_filt and once for vunder.

Test Plan:
- Reset then ena=1, otrip=3, brout_filt=0:
  - out_unbuf=1 for 64+ cycles, then 0; state reaches MONITOR.
  - otrip_decoded=8'h08; osc_ena=1.
- In MONITOR, pulse brout_filt high for 10 cycles:
  - out_unbuf rises 3 cycles after the rising edge.
  - out_unbuf stays high 1024 cycles after brout_s falls, then drops.
- short_hold=1, same pulse → out_unbuf held 16 cycles after brout_s falls.
- Re-assert brout_filt at HOLD cycle 500 → state returns to TRIP; full 1024-cycle hold restarts after release.
- Change vtrip 2→5 in MONITOR:
  - vtrip_decoded 8'h04→8'h20.
  - state goes to SETTLE; out_unbuf=1 for 64 cycles; brout_filt activity is ignored during that window.
- vunder pulse in MONITOR → vunder_sticky=1 and stays high; vunder_clr pulse clears it. Then ena=0 → state OFF, decodes 0, out_unbuf=1.
